// File: rtl/m_demux4_deser_if.sv
// m_demux4_deser_if
//   Bundles the slot stream, the direct-write controls and the channel
//   outputs of the four-slot demultiplexer.
//
//   Stream inputs  : D[WIDTH], VALID, SYNC
//   Direct inputs  : DIRECT, A (select LSB), B (select MSB)
//   Outputs        : Q_0..Q_3[WIDTH], QV (commit pulse), ERR (framing error
//                    pulse), LOCK (in RUN state)
//   Debug outputs  : DBG_STATE (0 = HUNT, 1 = RUN), DBG_SLOT (slot counter)
//
//   Handshake: a slot is transferred on every rising clock edge at which
//   VALID is high. There is no back-pressure; the demultiplexer accepts every
//   valid slot. SYNC, A and B are meaningful only together with VALID or
//   DIRECT as described in the design file.
interface m_demux4_deser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             VALID;
    logic             SYNC;
    logic             DIRECT;
    logic             A;
    logic             B;
    logic [WIDTH-1:0] Q_0;
    logic [WIDTH-1:0] Q_1;
    logic [WIDTH-1:0] Q_2;
    logic [WIDTH-1:0] Q_3;
    logic             QV;
    logic             ERR;
    logic             LOCK;
    logic             DBG_STATE;
    logic [1:0]       DBG_SLOT;

    // Source side: drives the stream and direct controls.
    modport master (
        output D, VALID, SYNC, DIRECT, A, B,
        input  Q_0, Q_1, Q_2, Q_3, QV, ERR, LOCK, DBG_STATE, DBG_SLOT
    );

    // Demultiplexer side.
    modport slave (
        input  D, VALID, SYNC, DIRECT, A, B,
        output Q_0, Q_1, Q_2, Q_3, QV, ERR, LOCK, DBG_STATE, DBG_SLOT
    );
endinterface

// File: rtl/m_demux4_deser.sv
// m_demux4_deser
//   Receiving end of a four-slot mux-based serializer. Successive valid
//   slots, with SYNC marking slot 0, are collected in shadow registers and
//   committed to Q_0..Q_3 together when slot 3 arrives. A direct mode writes
//   one output selected by {B,A} and drops the framer back to HUNT.
//
//   Ports:
//     CLK    : clock, rising edge
//     RESETL : asynchronous active-low reset
//     bus    : m_demux4_deser_if.slave (stream, direct controls, outputs,
//              debug state/slot)
module m_demux4_deser #(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESETL,
    m_demux4_deser_if.slave       bus
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] s_q [3];
    logic [WIDTH-1:0] s_d [3];
    logic [WIDTH-1:0] q_q [4];
    logic [WIDTH-1:0] q_d [4];
    logic             qv_q, qv_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            qv_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) s_q[i] <= '0;
            for (int i = 0; i < 4; i++) q_q[i] <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            qv_q    <= qv_d;
            err_q   <= err_d;
            for (int i = 0; i < 3; i++) s_q[i] <= s_d[i];
            for (int i = 0; i < 4; i++) q_q[i] <= q_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        qv_d    = 1'b0;
        err_d   = 1'b0;
        for (int i = 0; i < 3; i++) s_d[i] = s_q[i];
        for (int i = 0; i < 4; i++) q_d[i] = q_q[i];

        if (bus.DIRECT) begin
            // Direct mode overrides framing: any frame in progress is
            // abandoned without an error, shadows are left as they are.
            state_d = HUNT;
            slot_d  = 2'd0;
            if (bus.VALID) begin
                q_d[{bus.B, bus.A}] = bus.D;
            end
        end else if (bus.VALID) begin
            unique case (state_q)
                HUNT: begin
                    // Words without SYNC are dropped silently while hunting.
                    if (bus.SYNC) begin
                        s_d[0]  = bus.D;
                        slot_d  = 2'd1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.SYNC) begin
                        // Normal start of frame at slot 0; anywhere else it
                        // is an early sync that restarts the frame.
                        if (slot_q != 2'd0) err_d = 1'b1;
                        s_d[0] = bus.D;
                        slot_d = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                err_d   = 1'b1;
                                state_d = HUNT;
                                slot_d  = 2'd0;
                            end
                            2'd1: begin
                                s_d[1] = bus.D;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                s_d[2] = bus.D;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                q_d[0] = s_q[0];
                                q_d[1] = s_q[1];
                                q_d[2] = s_q[2];
                                q_d[3] = bus.D;
                                qv_d   = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.Q_0       = q_q[0];
    assign bus.Q_1       = q_q[1];
    assign bus.Q_2       = q_q[2];
    assign bus.Q_3       = q_q[3];
    assign bus.QV        = qv_q;
    assign bus.ERR       = err_q;
    assign bus.LOCK      = (state_q == RUN);
    assign bus.DBG_STATE = state_q;
    assign bus.DBG_SLOT  = slot_q;

endmodule

// File: tb/tb_m_demux4_deser.sv
module tb_m_demux4_deser;

    localparam int WIDTH = 8;

    logic CLK;
    logic RESETL;
    int   tests;
    int   fails;

    m_demux4_deser_if #(.WIDTH(WIDTH)) bus ();

    m_demux4_deser #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RESETL (RESETL),
        .bus    (bus)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Comparison helper
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, ".Q_0"}, 32'(bus.Q_0), 32'(e0));
        chk({tag, ".Q_1"}, 32'(bus.Q_1), 32'(e1));
        chk({tag, ".Q_2"}, 32'(bus.Q_2), 32'(e2));
        chk({tag, ".Q_3"}, 32'(bus.Q_3), 32'(e3));
    endtask

    task automatic chk_flags(input string tag, input logic qv, input logic err, input logic lock);
        chk({tag, ".QV"},   32'(bus.QV),   32'(qv));
        chk({tag, ".ERR"},  32'(bus.ERR),  32'(err));
        chk({tag, ".LOCK"}, 32'(bus.LOCK), 32'(lock));
    endtask

    // Driver: inputs set on the falling edge, outputs sampled 1 after the
    // rising edge.
    task automatic step(input logic v, input logic s, input logic dir,
                        input logic [1:0] sel, input logic [7:0] d);
        @(negedge CLK);
        bus.VALID  = v;
        bus.SYNC   = s;
        bus.DIRECT = dir;
        bus.B      = sel[1];
        bus.A      = sel[0];
        bus.D      = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic slot(input logic s, input logic [7:0] d);
        step(1'b1, s, 1'b0, 2'd0, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RESETL     = 1'b0;
        bus.D      = '0;
        bus.VALID  = 1'b0;
        bus.SYNC   = 1'b0;
        bus.DIRECT = 1'b0;
        bus.A      = 1'b0;
        bus.B      = 1'b0;

        // Reset state
        #12;
        chk_q("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RESETL = 1'b1;

        // SYNC without VALID is ignored in HUNT
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h99);
        chk("sync_no_valid.LOCK", 32'(bus.LOCK), 32'd0);

        // First frame 11,22,33,44
        slot(1'b1, 8'h11);
        chk_flags("f1.s0", 1'b0, 1'b0, 1'b1);
        chk("f1.s0.SLOT", 32'(bus.DBG_SLOT), 32'd1);
        slot(1'b0, 8'h22);
        slot(1'b0, 8'h33);
        chk_q("f1.s2", 8'h00, 8'h00, 8'h00, 8'h00);
        slot(1'b0, 8'h44);
        chk_q("f1.commit", 8'h11, 8'h22, 8'h33, 8'h44);
        chk_flags("f1.commit", 1'b1, 1'b0, 1'b1);
        idle();
        chk_flags("f1.after", 1'b0, 1'b0, 1'b1);

        // Back-to-back frames, second one with 3-cycle gaps
        slot(1'b1, 8'h01);
        slot(1'b0, 8'h02);
        slot(1'b0, 8'h03);
        slot(1'b0, 8'h04);
        chk_q("f2.commit", 8'h01, 8'h02, 8'h03, 8'h04);
        chk_flags("f2.commit", 1'b1, 1'b0, 1'b1);
        slot(1'b1, 8'h05);
        chk("f3.s0.QV", 32'(bus.QV), 32'd0);
        idle(); idle(); idle();
        slot(1'b0, 8'h06);
        idle(); idle(); idle();
        slot(1'b0, 8'h07);
        idle(); idle(); idle();
        chk_q("f3.hold", 8'h01, 8'h02, 8'h03, 8'h04);
        chk_flags("f3.gap", 1'b0, 1'b0, 1'b1);
        slot(1'b0, 8'h08);
        chk_q("f3.commit", 8'h05, 8'h06, 8'h07, 8'h08);
        chk_flags("f3.commit", 1'b1, 1'b0, 1'b1);

        // Early sync: 11,22 then SYNC with AA
        slot(1'b1, 8'h11);
        slot(1'b0, 8'h22);
        slot(1'b1, 8'hAA);
        chk_flags("early.sync", 1'b0, 1'b1, 1'b1);
        chk_q("early.sync", 8'h05, 8'h06, 8'h07, 8'h08);
        slot(1'b0, 8'hBB);
        chk("early.bb.ERR", 32'(bus.ERR), 32'd0);
        slot(1'b0, 8'hCC);
        slot(1'b0, 8'hDD);
        chk_q("early.commit", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        chk_flags("early.commit", 1'b1, 1'b0, 1'b1);

        // Missing sync at slot 0
        slot(1'b0, 8'h77);
        chk_flags("nosync", 1'b0, 1'b1, 1'b0);
        slot(1'b0, 8'h88);
        chk_flags("hunt.ignore", 1'b0, 1'b0, 1'b0);
        slot(1'b0, 8'h89);
        chk_q("hunt.ignore", 8'hAA, 8'hBB, 8'hCC, 8'hDD);

        // Direct writes; enter RUN first to see DIRECT force HUNT
        slot(1'b1, 8'h12);
        chk("pre_direct.LOCK", 32'(bus.LOCK), 32'd1);
        step(1'b1, 1'b0, 1'b1, 2'd2, 8'h5A);
        chk_q("direct2", 8'hAA, 8'hBB, 8'h5A, 8'hDD);
        chk_flags("direct2", 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'd3, 8'hC3);
        chk_q("direct3", 8'hAA, 8'hBB, 8'h5A, 8'hC3);
        chk_flags("direct3", 1'b0, 1'b0, 1'b0);
        // Non-sync word after direct mode is ignored (still hunting)
        slot(1'b0, 8'h44);
        chk_flags("post_direct", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        slot(1'b1, 8'h01);
        slot(1'b0, 8'h02);
        #2;
        RESETL = 1'b0;
        #1;
        chk_q("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst.SLOT", 32'(bus.DBG_SLOT), 32'd0);
        @(negedge CLK);
        RESETL = 1'b1;
        slot(1'b1, 8'h9A);
        slot(1'b0, 8'h9B);
        slot(1'b0, 8'h9C);
        chk_q("rst.partial", 8'h00, 8'h00, 8'h00, 8'h00);
        slot(1'b0, 8'h9D);
        chk_q("rst.commit", 8'h9A, 8'h9B, 8'h9C, 8'h9D);
        chk_flags("rst.commit", 1'b1, 1'b0, 1'b1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m_demux4_deser.md
Name: m_demux4_deser

Overview:
- Four-slot time-division demultiplexer/deserializer: the receiving end of a 4:1 mux-based slot serializer.
- Takes one data stream, with a sync flag marking slot 0, and distributes successive slots into four registered outputs Q_0..Q_3.
- Outputs update atomically once per complete frame.
- A direct-addressed mode writes a single output selected by B,A using the same select encoding as the mux: {B,A}=0 selects D_0/Q_0, 3 selects D_3/Q_3.

Parameters:
- WIDTH, 8, data width of D and of each Q_n.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESETL  input  1  reset, asynchronous, active-low.
- D  input  WIDTH  slot data.
- VALID  input  1  D is valid this cycle.
- SYNC  input  1  qualifies VALID; marks the current slot as slot 0 of a frame.
- DIRECT  input  1  1 = direct-addressed write mode.
- A  input  1  direct-mode select LSB.
- B  input  1  direct-mode select MSB.
- Q_0..Q_3  output  WIDTH each  registered channel outputs.
- QV  output  1  one-cycle pulse: a new frame was committed to Q_0..Q_3.
- ERR  output  1  one-cycle pulse: framing error.
- LOCK  output  1  1 while in RUN state.

Behaviour:
- Reset: RESETL low asynchronously clears everything, independent of CLK: Q_0..Q_3=0, QV=0, ERR=0, LOCK=0, state=HUNT, slot counter SLOT[1:0]=0, shadow registers S0..S2=0. A partial frame in progress at reset is discarded.
- QV and ERR are registered pulses, high for exactly the cycle after the triggering edge; default 0 every cycle.
- Q_n hold their value until the next frame commit or direct write.
- State HUNT:
  - VALID&SYNC: S0<=D, SLOT<=1, go to RUN.
  - VALID&!SYNC: ignored; no ERR.
- State RUN (LOCK=1), on VALID:
  - SLOT=1..2, !SYNC: S[SLOT]<=D, SLOT<=SLOT+1.
  - SLOT=3, !SYNC: commit. Q_0<=S0, Q_1<=S1, Q_2<=S2, Q_3<=D, all on the same edge. QV pulses. SLOT wraps to 0; stay in RUN.
  - SLOT=0, SYNC: S0<=D, SLOT<=1 (normal next frame).
  - SLOT=0, !SYNC: ERR pulses, go to HUNT, SLOT<=0.
  - SLOT=1..3, SYNC (early sync): ERR pulses, partial frame discarded, resync: S0<=D, SLOT<=1, remain in RUN; Q unchanged.
- !VALID: no state change in any state. Gaps between slots are legal and of unlimited length.
- Latency: the Q_0..Q_3 update and QV are visible one cycle after the clock edge sampling the slot-3 VALID.
- DIRECT=1 has priority over the framing logic:
  - VALID: Q[{B,A}]<=D. Other Q unchanged, QV=0.
  - Any cycle with DIRECT=1: state forced to HUNT, SLOT<=0, shadows unchanged. No ERR.
  - A frame in progress when DIRECT rises is abandoned silently.
- SYNC without VALID is ignored.
- A, B are ignored when DIRECT=0.

Test Plan:
- Reset, then VALID frames (SYNC on first) D=11,22,33,44 → after 4th edge Q_0..Q_3=11,22,33,44; QV high one cycle; LOCK=1.
- Back-to-back frames 01,02,03,04 then 05,06,07,08 with VALID gaps of 0 and 3 cycles → two QV pulses; final Q=05,06,07,08; Q holds 01..04 until the second commit.
- Frame 11,22 then SYNC with AA, then BB,CC,DD → ERR pulse on the AA edge; Q=AA,BB,CC,DD; no QV for the aborted frame.
- After a committed frame, VALID&!SYNC at SLOT=0 → ERR pulse, LOCK=0; following VALID&!SYNC words ignored; Q unchanged.
- DIRECT=1 with {B,A}=2, D=5A, VALID → Q_2=5A, others unchanged, QV=0, LOCK=0. Then {B,A}=3, D=C3 → Q_3=C3.
- Mid-frame (2 slots captured) drive RESETL low between clock edges → all outputs 0 immediately; after release, a full frame commits normally.
